// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types: widths, the buffered entry layout and the
// misalignment helper used when an entry is written.
package riscv_fetch_pkg;

    localparam int unsigned PC_W = 48;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            pred_taken;
        logic            misaligned;
    } fetch_entry_t;

    // A fetch target is misaligned when its low two address bits are non-zero.
    function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: the fetch-side push channel and the
// decode-side pop channel of the instruction fetch buffer.
interface fetch_buffer_if;
    import riscv_fetch_pkg::*;

    logic            in_valid;
    logic [PC_W-1:0] in_pc;
    logic [ILEN-1:0] in_instr;
    logic            in_pred_taken;
    logic            in_ready;

    logic            out_valid;
    logic [PC_W-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_pred_taken;
    logic            out_misaligned;
    logic            out_ready;

    // Producer/consumer side: presents fetch tuples and decode acceptance.
    modport master (
        output in_valid, in_pc, in_instr, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pred_taken, out_misaligned
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_pc, in_instr, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pred_taken, out_misaligned
    );

endinterface

// File: rtl/fetch_buffer.sv
// In-order instruction fetch buffer between fetch and decode. Entries are
// pushed with a valid/ready handshake, popped in FIFO order, and discarded
// wholesale on a misprediction flush. No empty bypass and no full bypass.
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       flush,
    fetch_buffer_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    in_ready_s;
    logic                    out_valid_s;
    logic                    push_s;
    logic                    pop_s;
    fetch_entry_t            wr_entry_s;
    fetch_entry_t            head_s;

    // Handshake qualification and head-entry presentation.
    always_comb begin
        in_ready_s  = (count_q != FULL_CNT);
        out_valid_s = (count_q != {CNT_W{1'b0}});
        push_s      = bus.in_valid  & in_ready_s  & ~flush;
        pop_s       = bus.out_ready & out_valid_s & ~flush;

        wr_entry_s.pc         = bus.in_pc;
        wr_entry_s.instr      = bus.in_instr;
        wr_entry_s.pred_taken = bus.in_pred_taken;
        wr_entry_s.misaligned = is_misaligned(bus.in_pc);

        head_s = mem_q[rd_ptr_q];
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_pc         = head_s.pc;
    assign bus.out_instr      = head_s.instr;
    assign bus.out_pred_taken = head_s.pred_taken;
    assign bus.out_misaligned = head_s.misaligned;
    assign count              = count_q;

    // Next pointers and occupancy; flush wins over any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: cleared by reset, untouched by flush, written on push.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: stimulus records every accepted tuple in
// an expected queue; an independent monitor compares each popped head.
module tb_fetch_buffer;
    import riscv_fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       n_reset;
    logic       flush;
    logic [2:0] count;

    fetch_buffer_if bus_if ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (flush),
        .bus     (bus_if),
        .count   (count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    fetch_entry_t exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every completed pop must match the oldest outstanding tuple.
    always @(negedge clk) begin
        if (n_reset && bus_if.out_valid && bus_if.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", bus_if.out_pc);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                chk("pop_pc",    64'(bus_if.out_pc),         64'(e.pc));
                chk("pop_instr", 64'(bus_if.out_instr),      64'(e.instr));
                chk("pop_pt",    64'(bus_if.out_pred_taken), 64'(e.pred_taken));
                chk("pop_mis",   64'(bus_if.out_misaligned), 64'(e.misaligned));
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [47:0] pc, input logic [31:0] ins,
                       input logic pt, input logic ordy, input logic fl);
        fetch_entry_t e;
        bus_if.in_valid      = v;
        bus_if.in_pc         = pc;
        bus_if.in_instr      = ins;
        bus_if.in_pred_taken = pt;
        bus_if.out_ready     = ordy;
        flush                = fl;
        @(negedge clk);
        if (fl) begin
            exp_q.delete();
        end else if (v && bus_if.in_ready) begin
            e.pc         = pc;
            e.instr      = ins;
            e.pred_taken = pt;
            e.misaligned = (pc % 48'd4) != 48'd0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 48'h0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        n_reset = 1'b0;
        flush   = 1'b0;
        bus_if.in_valid      = 1'b0;
        bus_if.in_pc         = '0;
        bus_if.in_instr      = '0;
        bus_if.in_pred_taken = 1'b0;
        bus_if.out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        idle(1'b0);

        // 1: reset then idle
        chk("rst_in_ready",  64'(bus_if.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_count",     64'(count),            64'd0);
        chk("rst_out_pc",    64'(bus_if.out_pc),    64'd0);

        // 2: fill to full, fifth tuple held off
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 48'h1000 + 48'(4 * k), 32'hA000_0000 + 32'(k), k[0], 1'b0, 1'b0);
            chk("fill_count", 64'(count), 64'(k + 1));
        end
        chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
        chk("full_head_pc",  64'(bus_if.out_pc),   64'h1000);
        cyc(1'b1, 48'h1010, 32'hA000_0010, 1'b0, 1'b0, 1'b0);
        chk("full_hold_count", 64'(count), 64'd4);
        idle(1'b1);
        chk("unfull_in_ready", 64'(bus_if.in_ready), 64'd1);
        repeat (3) idle(1'b1);
        chk("drain_count", 64'(count), 64'd0);

        // 3: continuous push/pop across pointer wrap
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 48'h2000 + 48'(4 * k), 32'hB000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd1);
        end
        idle(1'b1);
        chk("stream_drain", 64'(count), 64'd0);

        // 4: flush beats push and pop
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 48'h3100 + 48'(4 * k), 32'hC000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        cyc(1'b1, 48'h3000, 32'hC000_3000, 1'b1, 1'b1, 1'b1);
        chk("flush_count",     64'(count),            64'd0);
        chk("flush_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("flush_in_ready",  64'(bus_if.in_ready),  64'd1);
        cyc(1'b0, 48'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 48'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("flush2_count", 64'(count), 64'd0);
        idle(1'b1);

        // 5: misaligned flag and prediction bit
        cyc(1'b1, 48'h4002, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
        chk("mis_flag",  64'(bus_if.out_misaligned), 64'd1);
        chk("mis_pt",    64'(bus_if.out_pred_taken), 64'd1);
        chk("mis_instr", 64'(bus_if.out_instr),      64'h13);
        idle(1'b1);

        // 6: asynchronous reset between edges
        cyc(1'b1, 48'h5100, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 48'h5104, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        bus_if.in_valid = 1'b0;
        #2;
        n_reset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_count",     64'(count),             64'd0);
        chk("arst_out_valid", 64'(bus_if.out_valid),  64'd0);
        chk("arst_in_ready",  64'(bus_if.in_ready),   64'd1);
        chk("arst_out_pc",    64'(bus_if.out_pc),     64'd0);
        chk("arst_out_instr", 64'(bus_if.out_instr),  64'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 48'h5000, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_pc", 64'(bus_if.out_pc), 64'h5000);
        idle(1'b1);
        idle(1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch buffer between the fetch stage and decode.
- Accepts (pc, instr, predicted-taken) tuples from fetch using a valid/ready handshake, stores them in a small in-order FIFO, and presents them to decode using the same handshake.
- Drives fetch's ready input, so fetch stalls when the buffer is full.
- Flushed by an execute-stage misprediction so wrong-path instructions are discarded.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- PC_W, 48, program counter width.
- ILEN, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- n_reset  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all entries (driven by mispred_ex).
- in_valid  input  1  fetch presents a tuple this cycle.
- in_pc  input  PC_W  address of in_instr.
- in_instr  input  ILEN  fetched instruction word.
- in_pred_taken  input  1  branch predictor redirected after this instruction.
- in_ready  output  1  buffer can accept a tuple this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  PC_W  head entry pc.
- out_instr  output  ILEN  head entry instruction.
- out_pred_taken  output  1  head entry prediction bit.
- out_misaligned  output  1  head entry pc[1:0] != 0 (fetch-misaligned trap hint).
- out_ready  input  1  decode accepts the head entry this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, n_reset low):
  - count = 0, read and write pointers = 0, all storage cleared to 0.
  - Outputs: in_ready = 1, out_valid = 0, out_pc = 0, out_instr = 0, out_pred_taken = 0, out_misaligned = 0.
- Handshake events:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - Both are sampled at the rising edge.
- Combinational outputs:
  - in_ready = (count != DEPTH). No dependence on out_ready, so there is no full-and-popping bypass.
  - out_valid = (count != 0).
  - out_* are driven combinationally from the entry at the read pointer.
- Push: write the tuple at the write pointer.
  - out_misaligned bit is computed from in_pc[1:0] at write time.
  - Write pointer increments modulo DEPTH; wraps DEPTH-1 -> 0.
- Pop: read pointer increments modulo DEPTH.
- Count update:
  - push & !pop: count + 1.
  - pop & !push: count - 1.
  - push & pop (legal whenever 0 < count < DEPTH): count unchanged.
- Latency: no empty-bypass. A tuple pushed in cycle N is visible at out_* in cycle N+1 at the earliest.
- Full (count == DEPTH):
  - in_ready = 0; in_valid is ignored and fetch must hold its tuple.
  - A pop in this cycle raises in_ready the next cycle.
- Empty (count == 0): out_valid = 0; out_ready is ignored and out_* hold the stale entry at the read pointer.
- Flush:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Next cycle: count = 0, both pointers = 0, out_valid = 0, in_ready = 1.
  - Storage contents are not cleared.
  - The tuple presented during the flush cycle is dropped.
  - Back-to-back flushes are legal and idempotent.
- Ordering: strictly FIFO; entries are never reordered or duplicated.
- Reset mid-operation: takes effect immediately regardless of clock or in-flight handshakes; all state returns to reset values.
- Verification invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the buffer is full. Implementation uses an explicit count register.

Decomposition:
- Shared package riscv_fetch_pkg holds:
  - localparams PC_W = 48 and ILEN = 32;
  - typedef struct packed fetch_entry_t {pc, instr, pred_taken, misaligned}.
- Storage is an array of fetch_entry_t.
- No sub-module: pointer and count logic plus the storage array stay inline.

Test Plan:
1. Reset then idle: hold n_reset low, release, no inputs -> in_ready = 1, out_valid = 0, count = 0, out_pc = 0.
2. Fill to full: push pc 0x1000, 0x1004, 0x1008, 0x100C with out_ready = 0 -> count steps 1..4; in_ready = 0 after the 4th push; out_pc = 0x1000; a 5th tuple (pc 0x1010) is held and not accepted.
3. Simultaneous push/pop with wrap: continuous in_valid and out_ready for 10 cycles, pcs 0x2000 + 4k -> count stays constant after the first push; out_pc sequence is 0x2000, 0x2004, ... in order across pointer wrap.
4. Flush priority: with count = 3, assert flush together with in_valid (pc 0x3000) and out_ready -> next cycle count = 0, out_valid = 0; pc 0x3000 never appears at out_pc.
5. Misaligned flag: push pc 0x4002, instr 0x00000013, pred_taken = 1 -> head shows out_misaligned = 1, out_pred_taken = 1, out_instr = 0x00000013.
6. Async reset mid-stream: with count = 2, pulse n_reset low between clock edges -> outputs return to reset values immediately; the next push of pc 0x5000 appears at the head.
